// File: rtl/timer_dev.sv
// timer_dev -- 32-bit programmable down-counter with interrupt.
//
// Register map (word offset on addr):
//   0 CTRL   : [0] Enable, [2:1] Mode (01 = auto-reload, others = one-shot),
//              [3] IM (interrupt mask). Reads back as {28'b0, CTRL[3:0]}.
//   1 PRESET : 32-bit reload value, read/write.
//   2 COUNT  : current count, read-only.
//   3 -      : reserved, reads 0, writes ignored.
//
// Ports:
//   clk   - clock, all state changes on rising edge
//   reset - asynchronous active-high reset
//   addr  - register word offset
//   we    - write enable, sampled on rising clk
//   din   - write data
//   dout  - combinational read data
//   irq   - interrupt request (irq_flag & IM)
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic en, im, mode1;
  logic wr_ctrl, wr_preset;

  assign en        = ctrl_q[0];
  assign im        = ctrl_q[3];
  assign mode1     = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // PRESET of 0 or 1 both land here after a single CNT cycle.
            count_q    <= 32'h0;
            irq_flag_q <= 1'b1;
            state_q    <= INT;
          end
        end
        INT: begin
          if (mode1) begin
            // Auto-reload: flag drops on this edge, giving a 1-cycle pulse.
            irq_flag_q <= 1'b0;
            state_q    <= LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // CPU writes come last so they override the hardware Enable clear and
      // acknowledge any pending interrupt on the same edge.
      if (wr_ctrl) begin
        ctrl_q     <= din[3:0];
        irq_flag_q <= 1'b0;
      end
      if (wr_preset) begin
        preset_q   <= din;
        irq_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = 32'h0;
    case (addr)
      2'd0:    dout = {28'h0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'h0;
    endcase
  end

  assign irq = irq_flag_q & im;

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have no parameters; count width is fixed at 32 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port addr, input, 2, word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port we, input, 1, register write enable, sampled on the rising clk edge.
REQ-006 SHALL have port din, input, 32, write data.
REQ-007 SHALL have port dout, output, 32, combinational read data.
REQ-008 SHALL have port irq, output, 1, interrupt request; drives one bit of the CP0 hardware interrupt vector.

Function
REQ-009 SHALL implement CTRL[3:0]: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask).
- Writes to CTRL store din[3:0].
- CTRL reads as {28'b0, CTRL[3:0]}.
REQ-010 SHALL decode Mode 00 as one-shot (mode 0) and 01 as auto-reload (mode 1); 10 and 11 SHALL behave as mode 0.
REQ-011 SHALL implement PRESET as a 32-bit read/write register.
REQ-012 SHALL make COUNT read-only; writes with addr=2 or addr=3 SHALL be ignored, and addr=3 SHALL read as 0.
REQ-013 SHALL run a 4-state FSM: IDLE, LOAD, CNT, INT.
REQ-014 IDLE: if CTRL.Enable=1, SHALL go to LOAD on the next edge; otherwise SHALL stay in IDLE, with COUNT holding its value.
REQ-015 LOAD: SHALL set COUNT<=PRESET and go to CNT.
REQ-016 CNT, with CTRL.Enable=0: SHALL go to IDLE with COUNT holding its value.
REQ-017 CNT, with CTRL.Enable=1 and COUNT>1: SHALL decrement COUNT by 1.
REQ-018 CNT, with CTRL.Enable=1 and COUNT<=1: SHALL set COUNT<=0, set the internal flag irq_flag, and go to INT.
REQ-019 INT, mode 0: SHALL clear CTRL.Enable and go to IDLE; irq_flag SHALL stay set.
REQ-020 INT, mode 1: SHALL go to LOAD and clear irq_flag on that edge, so the irq pulse lasts exactly one cycle.
REQ-021 SHALL drive irq = irq_flag & CTRL.IM, combinationally from registers.
REQ-022 Any CPU write to CTRL or PRESET SHALL clear irq_flag on that edge; this is how mode-0 interrupts are acknowledged.
REQ-023 A CPU CTRL write in the same cycle as a hardware Enable clear (INT, mode 0) SHALL win; the CTRL value written is what is stored.
REQ-024 A PRESET write during CNT SHALL NOT change COUNT; the new value takes effect at the next LOAD.
REQ-025 PRESET=0 and PRESET=1 SHALL both yield exactly one CNT cycle before INT.
REQ-026 Latency: from the edge that stores Enable=1 with PRESET=N (N>=1), irq SHALL rise N+2 edges later, provided IM=1.
REQ-027 Clearing IM SHALL mask irq without clearing irq_flag; setting IM again re-exposes a pending irq_flag unless it was cleared by the same write (REQ-022).

Reset
REQ-028 reset=1 SHALL asynchronously force the following, independent of clk:
- CTRL=0, PRESET=0, COUNT=0
- irq_flag=0, FSM=IDLE
- hence irq=0, and dout=0 for addr 0 and 2.
REQ-029 Assertion of reset mid-count or in INT SHALL abort the operation; after release, the timer SHALL stay in IDLE until Enable is written.

Verification
REQ-030 Mode 0, PRESET=3, CTRL=0x9 written at edge e0 -> LOAD after e1; COUNT=3,2,1,0 after e2..e5; irq=1 after e5; IDLE with Enable=0 after e6; irq stays 1 until a CTRL write clears it.
REQ-031 Mode 1, PRESET=2, CTRL=0xB -> irq high for exactly one cycle; COUNT reloads to 2 the edge after INT; pulses repeat every 4 cycles.
REQ-032 CTRL=0x1 (IM=0), PRESET=1 -> irq never asserts, while COUNT reaches 0 and the FSM passes through INT; a later write of CTRL=0x8 -> irq=0, because the write cleared irq_flag.
REQ-033 Enable cleared mid-count at COUNT=5 -> COUNT holds 5 in IDLE; Enable set again -> reload from PRESET rather than resume.
REQ-034 reset pulsed asynchronously between clk edges while in CNT with COUNT=7 -> immediately COUNT=0, irq=0, CTRL=0; no further counting after release.
REQ-035 Writes to addr 2 and 3 with din=0xFFFFFFFF -> no register change; reads of addr 3 return 0, and reads of CTRL return only bits [3:0].
